// File: rtl/sync_async_pkg.sv
// Shared definitions for the slow-to-fast sig2 consumer: parameter defaults
// and the measurement FSM encoding.
package sync_async_pkg;

  localparam int unsigned FILT_DEF  = 2;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned EVT_W_DEF = 8;

  // Filter run-length counter width; covers FILT up to 15.
  localparam int unsigned FCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sig_glitch_filter.sv
// De-glitch filter for sig2: accepts a new level after FILT consecutive
// samples and flags each accepted transition.
module sig_glitch_filter
  import sync_async_pkg::*;
#(
  parameter int unsigned FILT = FILT_DEF
) (
  input  logic clk2,
  input  logic rstn,
  input  logic sig2,
  output logic sig_f,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic rise_c,
  output logic fall_c
);

  logic [FCNT_W-1:0] run_cnt;
  logic              toggle_c;

  // Toggle on the FILT-th consecutive differing sample.
  assign toggle_c = (sig2 != sig_f) && (run_cnt == FCNT_W'(FILT - 1));
  assign rise_c   = toggle_c && !sig_f;
  assign fall_c   = toggle_c && sig_f;

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      run_cnt    <= '0;
      sig_f      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_c;
      fall_pulse <= fall_c;
      if ((sig2 == sig_f) || toggle_c) begin
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
      if (toggle_c) begin
        sig_f <= ~sig_f;
      end
    end
  end

endmodule

// File: rtl/sig2_pulse_monitor.sv
// Fast-domain sig2 consumer: filtered edges, high-pulse width measurement
// with valid/ready handoff, wrapping event counter and sticky overrun.
module sig2_pulse_monitor
  import sync_async_pkg::*;
#(
  parameter int unsigned FILT  = FILT_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned EVT_W = EVT_W_DEF
) (
  input  logic             clk2,
  input  logic             rstn,
  input  logic             sig2,
  input  logic             clr,
  input  logic             len_ready,
  output logic             sig_f,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] high_len,
  output logic             len_sat,
  output logic             len_valid,
  output logic [EVT_W-1:0] evt_cnt,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state, state_d;
  logic             rise_c, fall_c;
  logic             start_c, load_c, accept_c, ovr_c;
  logic [CNT_W-1:0] width_cnt;
  logic             width_sat;

  sig_glitch_filter #(.FILT(FILT)) u_filter (
    .clk2       (clk2),
    .rstn       (rstn),
    .sig2       (sig2),
    .sig_f      (sig_f),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .rise_c     (rise_c),
    .fall_c     (fall_c)
  );

  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM acts on the same edge the filter accepts a transition, so len_valid
  // lines up with fall_pulse.
  always_comb begin
    state_d  = state;
    start_c  = 1'b0;
    load_c   = 1'b0;
    accept_c = 1'b0;
    ovr_c    = 1'b0;
    case (state)
      IDLE: begin
        if (rise_c) begin
          start_c = 1'b1;
          state_d = MEAS;
        end
      end
      MEAS: begin
        if (fall_c) begin
          load_c  = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (len_valid && len_ready) begin
          accept_c = 1'b1;
          if (rise_c) begin
            start_c = 1'b1;
            state_d = MEAS;
          end else begin
            state_d = IDLE;
          end
        end else if (rise_c) begin
          ovr_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Width counter and result registers.
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      width_cnt <= '0;
      width_sat <= 1'b0;
      high_len  <= '0;
      len_sat   <= 1'b0;
      len_valid <= 1'b0;
    end else begin
      if (start_c) begin
        width_cnt <= CNT_W'(1);
        width_sat <= 1'b0;
      end else if ((state == MEAS) && !fall_c) begin
        if (width_cnt == CNT_MAX) begin
          width_sat <= 1'b1;
        end else begin
          width_cnt <= width_cnt + 1'b1;
        end
      end
      if (load_c) begin
        high_len  <= width_cnt;
        len_sat   <= width_sat;
        len_valid <= 1'b1;
      end else if (accept_c) begin
        len_valid <= 1'b0;
      end
    end
  end

  // Event counter (clr wins) and sticky overrun (set wins).
  always_ff @(posedge clk2 or negedge rstn) begin
    if (!rstn) begin
      evt_cnt <= '0;
      overrun <= 1'b0;
    end else begin
      if (clr) begin
        evt_cnt <= '0;
      end else if (rise_pulse) begin
        evt_cnt <= evt_cnt + 1'b1;
      end
      if (ovr_c) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule
